// File: rtl/riscpipe_pkg.sv
// rtl/riscpipe_pkg.sv - shared opcodes and hazard shadow-entry type for the 5-stage core
package riscpipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_IMM   = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_BR    = 6'd2;
  localparam logic [5:0] OP_SW    = 6'd43;

  // One in-flight instruction as seen by the hazard unit.
  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [4:0] dst;
    logic       is_load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // True when a valid source register is produced by a valid, writing entry.
  function automatic logic src_hit(shadow_entry_t e, logic src_valid, logic [4:0] src);
    return e.valid & e.wr & src_valid & (e.dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_decode.sv
// rtl/hazard_ctrl_decode.sv - combinational source/destination decode for hazard detection
import riscpipe_pkg::*;

module hazard_decode (
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  output logic          src_a_valid,
  output logic [4:0]    src_a,
  output logic          src_b_valid,
  output logic [4:0]    src_b,
  output shadow_entry_t entry
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_instr;

  assign opcode       = id_instr[31:26];
  assign rs           = id_instr[25:21];
  assign rt           = id_instr[20:16];
  assign rd           = id_instr[15:11];
  assign unused_instr = ^id_instr[10:0];
  assign src_a        = rs;
  assign src_b        = rt;

  // Classify the opcode; r0 never counts as a source or destination.
  always_comb begin
    logic       use_a;
    logic       use_b;
    logic       has_dst;
    logic [4:0] dst;
    use_a   = 1'b0;
    use_b   = 1'b0;
    has_dst = 1'b0;
    dst     = 5'd0;
    entry   = SHADOW_BUBBLE;
    case (opcode)
      OP_RTYPE: begin use_a = 1'b1; use_b = 1'b1; has_dst = 1'b1; dst = rd; end
      OP_IMM:   begin use_a = 1'b1; has_dst = 1'b1; dst = rt; end
      OP_LW:    begin use_a = 1'b1; has_dst = 1'b1; dst = rt; end
      OP_SW:    begin use_a = 1'b1; use_b = 1'b1; end
      OP_BR:    begin use_a = 1'b1; use_b = 1'b1; end
      default:  begin end
    endcase
    src_a_valid   = id_valid & use_a & (rs != 5'd0);
    src_b_valid   = id_valid & use_b & (rt != 5'd0);
    entry.valid   = id_valid;
    entry.wr      = id_valid & has_dst & (dst != 5'd0);
    entry.dst     = dst;
    entry.is_load = id_valid & (opcode == OP_LW);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW hazard stall/flush control with shadow pipeline; option HAZARD_FWD_EN
import riscpipe_pkg::*;

module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic          src_a_valid;
  logic [4:0]    src_a;
  logic          src_b_valid;
  logic [4:0]    src_b;
  shadow_entry_t id_entry;

  shadow_entry_t ex_q, ex_d;
  shadow_entry_t mem_q, mem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic flush;

  hazard_decode u_decode (
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .src_a_valid (src_a_valid),
    .src_a       (src_a),
    .src_b_valid (src_b_valid),
    .src_b       (src_b),
    .entry       (id_entry)
  );

`ifdef HAZARD_FWD_EN
  logic unused_shadow;
  assign unused_shadow = ^mem_q;

  // With forwarding, only a load sitting in EX cannot supply its result in time.
  always_comb begin
    hazard = ex_q.is_load &
             (src_hit(ex_q, src_a_valid, src_a) | src_hit(ex_q, src_b_valid, src_b));
  end
`else
  logic unused_shadow;
  assign unused_shadow = ex_q.is_load ^ mem_q.is_load;

  // Without forwarding, any writer still in EX or MEM blocks the consumer.
  always_comb begin
    hazard = src_hit(ex_q, src_a_valid, src_a)  | src_hit(ex_q, src_b_valid, src_b) |
             src_hit(mem_q, src_a_valid, src_a) | src_hit(mem_q, src_b_valid, src_b);
  end
`endif

  // Zero-latency control outputs; reset forces the free-running defaults and a flush beats a stall.
  always_comb begin
    flush       = rst_n & ex_branch_taken;
    stall       = rst_n & hazard & ~ex_branch_taken;
    pc_write    = ~stall;
    if_id_write = ~stall;
    if_id_flush = flush;
    id_ex_flush = flush;
  end

  // Advance the shadow pipeline, inserting a bubble on stall or flush, and bump saturating counters.
  always_comb begin
    ex_d        = (stall | flush) ? SHADOW_BUBBLE : id_entry;
    mem_d       = ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= SHADOW_BUBBLE;
      mem_q       <= SHADOW_BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_branch_taken;

  logic        stall, pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall4, pc_write4, if_id_write4, if_id_flush4, id_ex_flush4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .ex_branch_taken(ex_branch_taken), .stall(stall4), .pc_write(pc_write4),
    .if_id_write(if_id_write4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] scnt16;
    logic [15:0] fcnt16;
    logic [3:0]  scnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   acc_stall = 0;
  int   acc_flush = 0;

  function automatic logic [31:0] enc(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, push expectation, compare after settle, then take the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic tk,
                      input logic rn, input logic exp_stall, input string tag);
    exp_t e;
    exp_t got;
    rst_n           = rn;
    id_valid        = v;
    id_instr        = ins;
    ex_branch_taken = tk;
    e.stall  = rn & exp_stall;
    e.flush  = rn & tk;
    e.scnt16 = 16'(sat(acc_stall, 65535));
    e.fcnt16 = 16'(sat(acc_flush, 65535));
    e.scnt4  = 4'(sat(acc_stall, 15));
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    chk({tag, ".stall"},       {31'd0, stall},        {31'd0, got.stall});
    chk({tag, ".pc_write"},    {31'd0, pc_write},     {31'd0, ~got.stall});
    chk({tag, ".if_id_write"}, {31'd0, if_id_write},  {31'd0, ~got.stall});
    chk({tag, ".if_id_flush"}, {31'd0, if_id_flush},  {31'd0, got.flush});
    chk({tag, ".id_ex_flush"}, {31'd0, id_ex_flush},  {31'd0, got.flush});
    chk({tag, ".stall_cnt"},   {16'd0, stall_cnt},    {16'd0, got.scnt16});
    chk({tag, ".flush_cnt"},   {16'd0, flush_cnt},    {16'd0, got.fcnt16});
    chk({tag, ".stall_cnt4"},  {28'd0, stall_cnt4},   {28'd0, got.scnt4});
    chk({tag, ".stall4"},      {31'd0, stall4},       {31'd0, got.stall});
    if (!rn) begin
      acc_stall = 0;
      acc_flush = 0;
    end else begin
      acc_stall += int'(exp_stall);
      acc_flush += int'(tk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, "drain");
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, "drain");
  endtask

  // Producer then consumer held in ID for nstall stall cycles, then released.
  task automatic run_pair(input logic [31:0] p, input logic [31:0] c, input int nstall, input string tag);
    step(1'b1, p, 1'b0, 1'b1, 1'b0, {tag, ".prod"});
    for (int i = 0; i < nstall; i++) step(1'b1, c, 1'b0, 1'b1, 1'b1, {tag, ".stall"});
    step(1'b1, c, 1'b0, 1'b1, 1'b0, {tag, ".go"});
  endtask

  logic [31:0] lw_r1, add_r3, addi_r1, add_r2, addi_r7, addi_r0, add_r5;

  initial begin
    lw_r1   = enc(6'd35, 5'd2, 5'd1, 5'd0);
    add_r3  = enc(6'd0,  5'd1, 5'd4, 5'd3);
    addi_r1 = enc(6'd10, 5'd2, 5'd1, 5'd0);
    add_r2  = enc(6'd0,  5'd1, 5'd1, 5'd2);
    addi_r7 = enc(6'd10, 5'd8, 5'd7, 5'd0);
    addi_r0 = enc(6'd10, 5'd3, 5'd0, 5'd0);
    add_r5  = enc(6'd0,  5'd0, 5'd0, 5'd5);

    rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; ex_branch_taken = 1'b0;
    @(posedge clk);
    #1;

    // Reset forces outputs even with a taken branch and a valid load present.
    step(1'b1, lw_r1, 1'b1, 1'b0, 1'b0, "rst");
    step(1'b1, add_r3, 1'b1, 1'b0, 1'b0, "rst2");
    drain();

    // Load-use.
    run_pair(lw_r1, add_r3, FWD ? 1 : 2, "loaduse");
    drain();

    // ALU producer directly ahead.
    run_pair(addi_r1, add_r2, FWD ? 0 : 2, "alu_adj");
    drain();

    // One independent instruction between producer and consumer.
    step(1'b1, addi_r1, 1'b0, 1'b1, 1'b0, "gap.prod");
    step(1'b1, addi_r7, 1'b0, 1'b1, 1'b0, "gap.mid");
    if (!FWD) step(1'b1, add_r2, 1'b0, 1'b1, 1'b1, "gap.stall");
    step(1'b1, add_r2, 1'b0, 1'b1, 1'b0, "gap.go");
    drain();

    // r0 is never a dependency.
    run_pair(addi_r0, add_r5, 0, "r0");
    drain();

    // Load-use coinciding with a taken branch: flush wins, EX becomes a bubble.
    step(1'b1, lw_r1, 1'b0, 1'b1, 1'b0, "flush.prod");
    step(1'b1, add_r3, 1'b1, 1'b1, 1'b0, "flush.hit");
    step(1'b1, add_r3, 1'b0, 1'b1, !FWD, "flush.after");
    if (!FWD) step(1'b1, add_r3, 1'b0, 1'b1, 1'b0, "flush.after2");
    drain();

    // Reset asserted during the last stall cycle of a load-use.
    step(1'b1, lw_r1, 1'b0, 1'b1, 1'b0, "rstmid.prod");
    if (!FWD) step(1'b1, add_r3, 1'b0, 1'b1, 1'b1, "rstmid.stall1");
    step(1'b1, add_r3, 1'b0, 1'b0, 1'b0, "rstmid.rst");
    step(1'b1, add_r3, 1'b0, 1'b1, 1'b0, "rstmid.rel");
    step(1'b1, add_r3, 1'b0, 1'b1, 1'b0, "rstmid.rel2");
    drain();

    // Repeated load-use to saturate the 4-bit counter.
    for (int k = 0; k < 20; k++) run_pair(lw_r1, add_r3, FWD ? 1 : 2, "sat");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
